// File: rtl/risc_run_ctrl_if.sv
// risc_run_ctrl_if: control/status bundle between a run master (host or
// debugger) and the risc_run_ctrl controller.
//
// Signals:
//   start      master -> ctrl  launch a run (accepted in IDLE or DONE)
//   abort      master -> ctrl  cancel any non-IDLE activity
//   step_mode  master -> ctrl  1 = single-step operation
//   step_req   master -> ctrl  step request (rising edge detected in ctrl)
//   halt_in    master -> ctrl  processor halt indication
//   cpu_en     ctrl -> master  processor clock-enable
//   cycle_cnt  ctrl -> master  enabled cycles in the current or last run
//   busy       ctrl -> master  run in progress (RUN, PAUSE or STEP)
//   done       ctrl -> master  run finished, held until start/abort/reset
//   timeout    ctrl -> master  run ended by the watchdog
//   step_ack   ctrl -> master  one-cycle pulse at the end of a step burst
interface risc_run_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic             step_mode;
  logic             step_req;
  logic             halt_in;
  logic             cpu_en;
  logic [CNT_W-1:0] cycle_cnt;
  logic             busy;
  logic             done;
  logic             timeout;
  logic             step_ack;

  modport master (
    output start, abort, step_mode, step_req, halt_in,
    input  cpu_en, cycle_cnt, busy, done, timeout, step_ack
  );

  modport slave (
    input  start, abort, step_mode, step_req, halt_in,
    output cpu_en, cycle_cnt, busy, done, timeout, step_ack
  );
endinterface

// File: rtl/risc_run_ctrl.sv
// risc_run_ctrl: run/step controller producing the clock-enable of a small
// processor. A run is launched with start, continues until halt_in (or the
// optional watchdog) ends it, and can be paused and advanced in bursts of
// STEP_BURST enabled cycles per step request.
//
// Ports:
//   clk    single clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    risc_run_ctrl_if.slave (start, abort, step_mode, step_req,
//          halt_in in; cpu_en, cycle_cnt, busy, done, timeout, step_ack out)
//
// Parameters:
//   CNT_W       width of the enabled-cycle counter
//   MAX_CYCLES  watchdog limit in enabled cycles (1 .. 2^CNT_W-1)
//   STEP_BURST  enabled cycles granted per step request (1 .. 255)
//
// Build option:
//   RISC_RUN_CTRL_WATCHDOG_EN  when defined, a run that reaches MAX_CYCLES
//   enabled cycles ends in DONE with timeout=1. When undefined, timeout is
//   tied to 0 and runs end only through halt_in or abort.
module risc_run_ctrl #(
  parameter int CNT_W      = 16,
  parameter int MAX_CYCLES = 16,
  parameter int STEP_BURST = 1
) (
  input logic            clk,
  input logic            rst_n,
  risc_run_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    PAUSE,
    STEP,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] cnt_nxt;
  logic [7:0]       burst;
  logic [7:0]       burst_nxt;
  logic             step_req_q;
  logic             step_edge;
  logic             cpu_en_q;
  logic             busy_q;
  logic             done_q;
  logic             step_last_q;

`ifdef RISC_RUN_CTRL_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(MAX_CYCLES);

  logic timeout_q;
  logic timeout_nxt;
  logic wd_hit;

  // The watchdog fires on the enabled cycle whose count reaches the limit,
  // so that cycle is still counted before the run stops.
  assign wd_hit      = (cnt_inc == WD_LIMIT);
  assign bus.timeout = timeout_q;
`else
  // MAX_CYCLES only matters to the watchdog.
  logic unused_max_cycles;
  assign unused_max_cycles = ^MAX_CYCLES;
  assign bus.timeout       = 1'b0;
`endif

  assign step_edge     = bus.step_req & ~step_req_q;
  assign cnt_inc       = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  assign bus.cpu_en    = cpu_en_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cycle_cnt = cnt;
  // A halt inside a burst cuts it short, so the ack is raised in that same
  // cycle rather than waiting for the registered last-burst flag.
  assign bus.step_ack  = step_last_q | ((state == STEP) & bus.halt_in & ~bus.abort);

  // Next-state decode. Priority inside RUN/STEP is abort, then halt_in,
  // then watchdog, then the normal mode/burst transitions. Abort is applied
  // last so it overrides everything and freezes the counter.
  always_comb begin
    state_nxt = state;
    burst_nxt = burst;
    cnt_nxt   = cnt;
`ifdef RISC_RUN_CTRL_WATCHDOG_EN
    timeout_nxt = timeout_q;
`endif
    if (state == RUN || state == STEP) begin
      cnt_nxt = cnt_inc;
    end

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          cnt_nxt   = '0;
          state_nxt = bus.step_mode ? PAUSE : RUN;
`ifdef RISC_RUN_CTRL_WATCHDOG_EN
          timeout_nxt = 1'b0;
`endif
        end
      end
      RUN: begin
        if (bus.halt_in) begin
          state_nxt = DONE;
        end
`ifdef RISC_RUN_CTRL_WATCHDOG_EN
        else if (wd_hit) begin
          state_nxt   = DONE;
          timeout_nxt = 1'b1;
        end
`endif
        else if (bus.step_mode) begin
          state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (step_edge) begin
          state_nxt = STEP;
          burst_nxt = 8'(STEP_BURST);
        end
      end
      STEP: begin
        if (bus.halt_in) begin
          state_nxt = DONE;
        end
`ifdef RISC_RUN_CTRL_WATCHDOG_EN
        else if (wd_hit) begin
          state_nxt   = DONE;
          timeout_nxt = 1'b1;
        end
`endif
        else if (burst == 8'd1) begin
          state_nxt = bus.step_mode ? PAUSE : RUN;
        end else begin
          burst_nxt = burst - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (bus.abort) begin
      state_nxt = IDLE;
      cnt_nxt   = cnt;
`ifdef RISC_RUN_CTRL_WATCHDOG_EN
      timeout_nxt = 1'b0;
`endif
    end
  end

  // State, counters and registered outputs. Outputs are decoded from the
  // next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      burst       <= '0;
      step_req_q  <= 1'b0;
      cpu_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      step_last_q <= 1'b0;
`ifdef RISC_RUN_CTRL_WATCHDOG_EN
      timeout_q   <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      burst       <= burst_nxt;
      step_req_q  <= bus.step_req;
      cpu_en_q    <= (state_nxt == RUN) || (state_nxt == STEP);
      busy_q      <= (state_nxt == RUN) || (state_nxt == PAUSE) || (state_nxt == STEP);
      done_q      <= (state_nxt == DONE);
      step_last_q <= (state_nxt == STEP) && (burst_nxt == 8'd1);
`ifdef RISC_RUN_CTRL_WATCHDOG_EN
      timeout_q   <= timeout_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_risc_run_ctrl.sv
// tb_risc_run_ctrl: directed bench for risc_run_ctrl. dut_a uses the default
// parameters, dut_b uses STEP_BURST=2. Each step drives inputs, queues the
// outputs expected after the next rising edge, and compares them once the
// edge has passed. Expectations follow the watchdog build option.
module tb_risc_run_ctrl;

  localparam int CNT_W = 16;
  localparam int VW    = CNT_W + 5;

  typedef struct {
    bit          sel;
    logic [VW-1:0] value;
    string       tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  risc_run_ctrl_if #(.CNT_W(CNT_W)) bus_a ();
  risc_run_ctrl_if #(.CNT_W(CNT_W)) bus_b ();

  risc_run_ctrl #(.CNT_W(CNT_W)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  risc_run_ctrl #(.CNT_W(CNT_W), .STEP_BURST(2)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  always #5 clk = ~clk;

  // Packs {cpu_en, busy, done, timeout, step_ack, cycle_cnt} of one DUT.
  function automatic logic [VW-1:0] observe(input bit sel);
    if (sel) begin
      return {bus_b.cpu_en, bus_b.busy, bus_b.done, bus_b.timeout, bus_b.step_ack, bus_b.cycle_cnt};
    end
    return {bus_a.cpu_en, bus_a.busy, bus_a.done, bus_a.timeout, bus_a.step_ack, bus_a.cycle_cnt};
  endfunction

  // Drives the selected DUT (the other one sees all-zero inputs) and queues
  // the outputs expected once this stimulus has been clocked in.
  task automatic applyStimulus(input bit sel, input bit st, input bit ab, input bit sm,
                               input bit sr, input bit hi, input bit e_en, input bit e_busy,
                               input bit e_done, input bit e_to, input bit e_ack,
                               input int e_cnt, input string tag);
    exp_t e;
    bus_a.start     = sel ? 1'b0 : st;
    bus_a.abort     = sel ? 1'b0 : ab;
    bus_a.step_mode = sel ? 1'b0 : sm;
    bus_a.step_req  = sel ? 1'b0 : sr;
    bus_a.halt_in   = sel ? 1'b0 : hi;
    bus_b.start     = sel ? st : 1'b0;
    bus_b.abort     = sel ? ab : 1'b0;
    bus_b.step_mode = sel ? sm : 1'b0;
    bus_b.step_req  = sel ? sr : 1'b0;
    bus_b.halt_in   = sel ? hi : 1'b0;
    e.sel   = sel;
    e.value = {e_en, e_busy, e_done, e_to, e_ack, CNT_W'(e_cnt)};
    e.tag   = tag;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t          e;
    logic [VW-1:0] obs;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("[TB] FAIL scoreboard_empty observed=none expected=entry");
      return;
    end
    e   = sb.pop_front();
    obs = observe(e.sel);
    assert (obs === e.value) else begin
      errors++;
      $error("[TB] FAIL %s dut%s observed en/busy/done/to/ack=%b cnt=%0d expected en/busy/done/to/ack=%b cnt=%0d",
             e.tag, e.sel ? "_b" : "_a", obs[VW-1:CNT_W], obs[CNT_W-1:0],
             e.value[VW-1:CNT_W], e.value[CNT_W-1:0]);
    end
  endtask

  // One clocked step: stimulus, rising edge, then compare just after it.
  task automatic stepCycle(input bit sel, input bit st, input bit ab, input bit sm,
                           input bit sr, input bit hi, input bit e_en, input bit e_busy,
                           input bit e_done, input bit e_to, input bit e_ack,
                           input int e_cnt, input string tag);
    applyStimulus(sel, st, ab, sm, sr, hi, e_en, e_busy, e_done, e_to, e_ack, e_cnt, tag);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=hung expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    // Power-on reset, checked on both instances before any clock edge.
    #2 rst_n = 1'b0;
    applyStimulus(0, 0,0,0,0,0, 0,0,0,0,0, 0, "reset_a");
    #1 checkOutput();
    applyStimulus(1, 0,0,0,0,0, 0,0,0,0,0, 0, "reset_b");
    checkOutput();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    stepCycle(0, 0,0,0,0,0, 0,0,0,0,0, 0, "idle_after_reset");

    // Free run with halt_in low.
    stepCycle(0, 1,0,0,0,0, 1,1,0,0,0, 0, "run_start");
    for (int i = 1; i <= 15; i++) stepCycle(0, 0,0,0,0,0, 1,1,0,0,0, i, "run_count");
`ifdef RISC_RUN_CTRL_WATCHDOG_EN
    stepCycle(0, 0,0,0,0,0, 0,0,1,1,0, 16, "watchdog_expire");
    stepCycle(0, 0,0,0,0,0, 0,0,1,1,0, 16, "watchdog_done_hold");
`else
    stepCycle(0, 0,0,0,0,0, 1,1,0,0,0, 16, "no_watchdog_16");
    stepCycle(0, 0,0,0,0,0, 1,1,0,0,0, 17, "no_watchdog_17");
    stepCycle(0, 0,0,0,0,1, 0,0,1,0,0, 18, "halt_ends_long_run");
`endif

    // Restart from DONE, halt on the 5th enabled cycle.
    stepCycle(0, 1,0,0,0,0, 1,1,0,0,0, 0, "restart_from_done");
    for (int i = 1; i <= 4; i++) stepCycle(0, 0,0,0,0,0, 1,1,0,0,0, i, "run_to_halt");
    stepCycle(0, 0,0,0,0,1, 0,0,1,0,0, 5, "halt_5th");
    stepCycle(0, 0,0,0,0,0, 0,0,1,0,0, 5, "done_hold");

    // Halt on the 16th enabled cycle wins over the watchdog.
    stepCycle(0, 1,0,0,0,0, 1,1,0,0,0, 0, "restart_for_16");
    for (int i = 1; i <= 15; i++) stepCycle(0, 0,0,0,0,0, 1,1,0,0,0, i, "run_to_16");
    stepCycle(0, 0,0,0,0,1, 0,0,1,0,0, 16, "halt_at_16");

    // Abort after 7 enabled cycles; a start mid-run is ignored.
    stepCycle(0, 1,0,0,0,0, 1,1,0,0,0, 0, "restart_for_abort");
    for (int i = 1; i <= 7; i++) stepCycle(0, (i == 3),0,0,0,0, 1,1,0,0,0, i, "start_ignored_busy");
    stepCycle(0, 0,1,0,0,0, 0,0,0,0,0, 7, "abort_to_idle");
    stepCycle(0, 0,0,0,0,0, 0,0,0,0,0, 7, "idle_hold_cnt");

    // Single-step with STEP_BURST=1, then step back into a free run.
    stepCycle(0, 1,0,1,0,0, 0,1,0,0,0, 0, "start_into_pause");
    stepCycle(0, 0,0,1,0,0, 0,1,0,0,0, 0, "pause_wait");
    stepCycle(0, 0,0,1,1,0, 1,1,0,0,1, 0, "single_step");
    stepCycle(0, 0,0,1,1,0, 0,1,0,0,0, 1, "step_back_pause");
    stepCycle(0, 0,0,1,1,0, 0,1,0,0,0, 1, "held_req_no_repeat");
    stepCycle(0, 0,0,0,0,0, 0,1,0,0,0, 1, "pause_mode_off");
    stepCycle(0, 0,0,0,1,0, 1,1,0,0,1, 1, "step_to_run");
    stepCycle(0, 0,0,0,0,0, 1,1,0,0,0, 2, "resume_run");
    stepCycle(0, 0,0,1,0,0, 0,1,0,0,0, 3, "run_to_pause");
    stepCycle(0, 0,1,0,0,0, 0,0,0,0,0, 3, "abort_from_pause");

    // Reset asserted in the middle of a run, away from the clock edge.
    stepCycle(0, 1,0,0,0,0, 1,1,0,0,0, 0, "run_before_reset");
    for (int i = 1; i <= 3; i++) stepCycle(0, 0,0,0,0,0, 1,1,0,0,0, i, "run_before_reset");
    #2 rst_n = 1'b0;
    applyStimulus(0, 0,0,0,0,0, 0,0,0,0,0, 0, "async_reset_mid_run");
    #1 checkOutput();
    stepCycle(0, 0,0,0,0,0, 0,0,0,0,0, 0, "reset_held_over_edge");
    bus_b.step_mode = 1'b1;
    bus_b.step_req  = 1'b1;
    rst_n = 1'b1;

    // dut_b: step_req high across reset release must not step.
    stepCycle(1, 1,0,1,1,0, 0,1,0,0,0, 0, "start_pause_req_high");
    stepCycle(1, 0,0,1,1,0, 0,1,0,0,0, 0, "held_req_after_reset");
    stepCycle(1, 0,0,1,0,0, 0,1,0,0,0, 0, "req_low");
    // Three step requests, each granting a 2-cycle burst.
    for (int p = 0; p < 3; p++) begin
      stepCycle(1, 0,0,1,1,0, 1,1,0,0,0, 2*p,     "burst_first");
      stepCycle(1, 0,0,1,0,0, 1,1,0,0,1, 2*p + 1, "burst_last_ack");
      stepCycle(1, 0,0,1,0,0, 0,1,0,0,0, 2*p + 2, "burst_back_pause");
    end
    stepCycle(1, 1,0,1,0,0, 0,1,0,0,0, 6, "start_ignored_pause");
    stepCycle(1, 0,0,1,1,0, 1,1,0,0,0, 6, "burst_before_halt");
    stepCycle(1, 0,0,1,1,1, 0,0,1,0,0, 7, "halt_in_step");
    stepCycle(1, 0,1,0,0,0, 0,0,0,0,0, 7, "abort_clears_done");

    // dut_a runs normally after reset; abort outranks a coincident halt.
    stepCycle(0, 1,0,0,0,0, 1,1,0,0,0, 0, "run_after_reset");
    for (int i = 1; i <= 2; i++) stepCycle(0, 0,0,0,0,0, 1,1,0,0,0, i, "run_after_reset");
    stepCycle(0, 0,1,0,0,1, 0,0,0,0,0, 2, "abort_beats_halt");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/risc_run_ctrl.md
RISC_RUN_CTRL -- requirements
Module: risc_run_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16: width of the enabled-cycle counter.
REQ-002 SHALL have parameter MAX_CYCLES, default 16: watchdog limit in enabled cycles; legal range 1..2^CNT_W-1.
REQ-003 SHALL have parameter STEP_BURST, default 1: enabled cycles granted per step request; legal range 1..255.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit: launch a run; accepted only in IDLE or DONE.
REQ-007 SHALL have port abort, input, 1 bit: cancel any non-IDLE activity.
REQ-008 SHALL have port step_mode, input, 1 bit: 1 selects single-step operation.
REQ-009 SHALL have port step_req, input, 1 bit: step request; rising edge detected internally.
REQ-010 SHALL have port halt_in, input, 1 bit: processor halt indication.
REQ-011 SHALL have port cpu_en, output, 1 bit: processor clock-enable.
REQ-012 SHALL have port cycle_cnt, output, CNT_W bits: number of enabled cycles in the current or last run.
REQ-013 SHALL have ports busy, done, timeout and step_ack, each output, 1 bit.

Function
REQ-014 SHALL implement states IDLE, RUN, PAUSE, STEP and DONE; cpu_en=1 only in RUN and STEP.
REQ-015 SHALL, in IDLE or DONE with start=1, clear cycle_cnt, clear done and timeout, and enter PAUSE if step_mode=1, otherwise RUN.
REQ-016 SHALL increment cycle_cnt once per cycle with cpu_en=1, saturating at all-ones.
REQ-017 SHALL, in RUN with halt_in=1, enter DONE; the halt cycle is counted; cpu_en=0 from the next cycle.
REQ-018 SHALL, in RUN, move to PAUSE at the next edge if step_mode=1.
REQ-019 SHALL, in PAUSE, enter STEP on a detected step_req rising edge and load a burst counter with STEP_BURST.
REQ-020 SHALL, in STEP, hold cpu_en=1 for exactly STEP_BURST cycles, pulse step_ack for 1 cycle on the last burst cycle, then return to PAUSE, or to RUN if step_mode=0.
REQ-021 SHALL, in STEP with halt_in=1, enter DONE; step_ack pulses in that cycle.
REQ-022 SHALL drive busy=1 in RUN, PAUSE and STEP.
REQ-023 SHALL hold done=1 in DONE until start, abort or reset.
REQ-024 SHALL ignore start while busy=1.
REQ-025 SHALL, on abort=1 in any non-IDLE state, enter IDLE at the next edge with cpu_en=0, done=0 and timeout=0, and hold cycle_cnt.
REQ-026 SHALL give abort priority over halt_in, watchdog and start; halt_in SHALL have priority over watchdog.
REQ-027 SHALL ignore step_req edges outside PAUSE; step_req held high SHALL NOT repeat a step.

Reset
REQ-028 SHALL, on rst_n=0, immediately force state IDLE and drive cpu_en, busy, done, timeout, step_ack and cycle_cnt to 0, including mid-run.
REQ-029 SHALL clear the step_req edge-detector history to 0 on reset, so step_req high at reset release SHALL NOT count as an edge.

Configuration
REQ-030 SHALL, with macro RISC_RUN_CTRL_WATCHDOG_EN defined, enter DONE with timeout=1 when an enabled cycle brings cycle_cnt to MAX_CYCLES; this applies in RUN and STEP.
REQ-031 SHALL, without RISC_RUN_CTRL_WATCHDOG_EN, omit the watchdog logic, tie timeout to 0, and end runs only by halt_in or abort.

Verification
REQ-032 SHALL verify: watchdog enabled, defaults, start pulse, halt_in=0 -> cpu_en high exactly 16 cycles, done=1, timeout=1, cycle_cnt=16.
REQ-033 SHALL verify: halt_in asserted on the 5th enabled cycle -> done=1, timeout=0, cycle_cnt=5, cpu_en low on the next cycle.
REQ-034 SHALL verify: STEP_BURST=2, step_mode=1, three step_req pulses -> three 2-cycle cpu_en bursts, three step_ack pulses, cycle_cnt=6, state PAUSE.
REQ-035 SHALL verify: abort after 7 enabled cycles -> IDLE, cpu_en=0 next cycle, busy=0, cycle_cnt=7.
REQ-036 SHALL verify: halt_in coincides with the 16th enabled cycle -> done=1, timeout=0, cycle_cnt=16.
REQ-037 SHALL verify: rst_n low mid-RUN -> all outputs 0 asynchronously; start after release -> normal run from cycle_cnt=0.
